input_conditioner: RTL

//   Synchronises and debounces raw board inputs (rotary encoder A/B/push on
//   iob[3:0]) in the clk_125mhz domain. Sits directly upstream of rotary_enc:
//   its clean[] levels replace raw iob[3:0] on rte_in. Also emits one-cycle

---
 rtl/input_conditioner.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//   Synchronises and debounces raw board inputs (rotary encoder A/B/push) in
//   the clk_125mhz domain. The clean levels are meant to replace the raw pads
//   on the downstream rotary encoder input. One-cycle edge pulses and
//   quadrature step/error events are produced for monitoring.
//
// Ports
//   clk_125mhz  in   1      system clock
//   reset       in   1      asynchronous, active-high
//   raw_in      in   WIDTH  unsynchronised pad inputs (bit0 = A, bit1 = B)
//   clean       out  WIDTH  debounced levels
//   rise        out  WIDTH  1-cycle pulse when clean[i] goes 0->1
//   fall        out  WIDTH  1-cycle pulse when clean[i] goes 1->0
//   step_inc    out  1      1-cycle pulse, valid count-up quadrature step
//   step_dec    out  1      1-cycle pulse, valid count-down quadrature step
//   quad_err    out  1      1-cycle pulse, A and B accepted on the same edge
//   err_cnt     out  8      saturating count of quad_err pulses
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int               WIDTH     = 4,
  parameter int               DB_CYCLES = 125000,
  parameter int               CNT_W     = 17,
  parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b1}}
) (
  input  logic             clk_125mhz,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             step_inc,
  output logic             step_dec,
  output logic             quad_err,
  output logic [7:0]       err_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // two-flop synchroniser; only s2 feeds the debouncer
  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  // debounce state
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] clean_q;
  logic [WIDTH-1:0] clean_d;

  // registered event outputs
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             step_inc_q;
  logic             step_inc_d;
  logic             step_dec_q;
  logic             step_dec_d;
  logic             quad_err_q;
  logic             quad_err_d;
  logic [7:0]       err_cnt_q;
  logic [7:0]       err_cnt_d;

  // quadrature helpers
  logic a_chg;
  logic b_chg;
  logic a_new;
  logic b_new;
  logic a_old;
  logic b_old;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      s1_q <= INIT;
      s2_q <= INIT;
    end else begin
      s1_q <= raw_in;
      s2_q <= s1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: each bit runs its own counter. The counter only advances while
  // the synchronised level differs from the accepted level; any return to
  // equality clears it, so a glitch shorter than DB_CYCLES never lands.
  // ---------------------------------------------------------------------------
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          clean_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      clean_q <= INIT;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      clean_q <= clean_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge pulses and quadrature decode. Everything is derived from the
  // clean_q -> clean_d transition so the pulses are registered on the very
  // edge that updates clean and are high for the first cycle of the new value.
  // ---------------------------------------------------------------------------
  always_comb begin
    rise_d = clean_d & ~clean_q;
    fall_d = ~clean_d & clean_q;

    a_old = clean_q[0];
    b_old = clean_q[1];
    a_new = clean_d[0];
    b_new = clean_d[1];
    a_chg = a_new ^ a_old;
    b_chg = b_new ^ b_old;

    step_inc_d = 1'b0;
    step_dec_d = 1'b0;
    quad_err_d = 1'b0;

    if (a_chg && b_chg) begin
      quad_err_d = 1'b1;
    end else if (a_chg) begin
      // A rises with B=0 or A falls with B=1 counts up
      if (a_new != b_old) step_inc_d = 1'b1;
      else                step_dec_d = 1'b1;
    end else if (b_chg) begin
      // B rises with A=1 or B falls with A=0 counts up
      if (b_new == a_old) step_inc_d = 1'b1;
      else                step_dec_d = 1'b1;
    end

    err_cnt_d = err_cnt_q;
    if (quad_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_125mhz or posedge reset) begin
    if (reset) begin
      rise_q     <= '0;
      fall_q     <= '0;
      step_inc_q <= 1'b0;
      step_dec_q <= 1'b0;
      quad_err_q <= 1'b0;
      err_cnt_q  <= 8'h00;
    end else begin
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      step_inc_q <= step_inc_d;
      step_dec_q <= step_dec_d;
      quad_err_q <= quad_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign clean    = clean_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign step_inc = step_inc_q;
  assign step_dec = step_dec_q;
  assign quad_err = quad_err_q;
  assign err_cnt  = err_cnt_q;

endmodule
